// File: rtl/iir_dir_pole_if.sv
// rtl/iir_dir_pole_if.sv - sample-in / sample-out handshake bundle for the IIR pole section
interface iir_dir_pole_if;
   logic signed [47:0] Xin;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] Yout;
   logic               out_valid;
   logic               out_ready;
   logic               ovf;

   modport master (output Xin, in_valid, out_ready,
                   input  in_ready, Yout, out_valid, ovf);
   modport slave  (input  Xin, in_valid, out_ready,
                   output in_ready, Yout, out_valid, ovf);
endinterface

// File: rtl/iir_dir_pole.sv
// rtl/iir_dir_pole.sv - recursive pole section of the direct-form IIR, one shared 16x32 MAC
module iir_dir_pole #(
   parameter int FRAC = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic signed [15:0] B1,
   input  logic signed [15:0] B2,
   input  logic signed [15:0] B3,
   input  logic signed [15:0] B4,
   input  logic signed [15:0] B5,
   input  logic signed [15:0] B6,
   input  logic signed [15:0] B7,
   iir_dir_pole_if.slave      bus
);
   typedef enum logic [1:0] {IDLE, MAC, DONE, HOLD} state_t;

   state_t             state, state_nxt;
   logic signed [15:0] coef   [7];
   logic signed [31:0] y_hist [7];   // y_hist[0] holds y[n-1]
   logic signed [51:0] acc;
   logic        [2:0]  k;
   logic signed [31:0] yout;
   logic               ovf_r;
   logic               out_valid_r;

   logic        [2:0]  idx;
   logic signed [47:0] coef_x, hist_x, prod;
   logic signed [51:0] shifted;
   logic               clip_hi, clip_lo;
   logic signed [31:0] sat_y;

   assign idx     = k - 3'd1;
   assign coef_x  = 48'(coef[idx]);
   assign hist_x  = 48'(y_hist[idx]);
   assign prod    = coef_x * hist_x;

   // Arithmetic shift floors toward -inf; anything outside 32 bits clips.
   assign shifted = acc >>> FRAC;
   assign clip_hi = !shifted[51] && (shifted[50:31] != '0);
   assign clip_lo =  shifted[51] && (shifted[50:31] != '1);
   assign sat_y   = clip_hi ? 32'sh7fff_ffff :
                    clip_lo ? 32'sh8000_0000 : shifted[31:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = MAC;
         MAC:     if (k == 3'd7)     state_nxt = DONE;
         DONE:                       state_nxt = HOLD;
         HOLD:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
      if (clr) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc         <= '0;
         k           <= '0;
         yout        <= '0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         for (int i = 0; i < 7; i++) begin
            y_hist[i] <= '0;
            coef[i]   <= '0;
         end
      end else if (clr) begin
         acc         <= '0;
         k           <= '0;
         yout        <= '0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         for (int i = 0; i < 7; i++) y_hist[i] <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               acc     <= {{4{bus.Xin[47]}}, bus.Xin};
               k       <= 3'd1;
               coef[0] <= B1;
               coef[1] <= B2;
               coef[2] <= B3;
               coef[3] <= B4;
               coef[4] <= B5;
               coef[5] <= B6;
               coef[6] <= B7;
            end
            MAC: begin
               acc <= acc - {{4{prod[47]}}, prod};
               k   <= k + 3'd1;
            end
            DONE: begin
               yout        <= sat_y;
               ovf_r       <= clip_hi | clip_lo;
               out_valid_r <= 1'b1;
               y_hist[0]   <= sat_y;
               for (int i = 1; i < 7; i++) y_hist[i] <= y_hist[i-1];
            end
            HOLD: if (bus.out_ready) out_valid_r <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.Yout      = yout;
   assign bus.ovf       = ovf_r;
   assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_iir_dir_pole.sv
// tb/tb_iir_dir_pole.sv - table-driven bench for iir_dir_pole plus handshake/abort/reset sequences
module tb_iir_dir_pole;
   typedef struct {
      logic               do_clr;
      logic [6:0][15:0]   bs;      // bs[0] = B1
      logic signed [47:0] xin;
      logic signed [31:0] y;
      logic               ovf;
   } vec_t;

   localparam logic [6:0][15:0] BZ = '0;
   localparam logic [6:0][15:0] BD = {96'd0, 16'hFC00};
   localparam logic [6:0][15:0] BM = {16'd16384, 16'd8192, 16'd4096, 16'd2048,
                                      16'd1024, 16'd512, 16'd256};

   logic               clk = 1'b0;
   logic               rst;
   logic               clr;
   logic signed [15:0] bq [7];
   int                 passed = 0;
   int                 total  = 0;
   vec_t               v [20];

   iir_dir_pole_if bus ();

   iir_dir_pole #(.FRAC(11)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .B1(bq[0]), .B2(bq[1]), .B3(bq[2]), .B4(bq[3]),
      .B5(bq[4]), .B6(bq[5]), .B7(bq[6]),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
   endtask

   task automatic accept(input string tag, input logic [6:0][15:0] bs, input logic signed [47:0] x);
      int w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_ready"}, bus.in_ready, 1);
      for (int i = 0; i < 7; i++) bq[i] = bs[i];
      bus.Xin      = x;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.Xin      = 48'h1234_5678_9abc;
      for (int i = 0; i < 7; i++) bq[i] = 16'sh7ace;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!bus.out_valid && lat < 20);
   endtask

   task automatic xfer(input string tag, input logic [6:0][15:0] bs,
                       input logic signed [47:0] x, input logic signed [31:0] y, input logic o);
      int lat;
      accept(tag, bs, x);
      wait_valid(lat);
      chk({tag, "_latency"}, lat, 8);
      chk({tag, "_yout"}, bus.Yout, y);
      chk({tag, "_ovf"}, bus.ovf, o);
      @(posedge clk);
      #1 chk({tag, "_consume"}, {bus.out_valid, bus.in_ready}, 2'b01);
   endtask

   initial begin
      int lat;
      int bad;

      v[0]  = '{1'b1, BZ, 48'sd2048000, 32'sd1000, 1'b0};
      v[1]  = '{1'b1, BD, 48'sd2097152, 32'sd1024, 1'b0};
      v[2]  = '{1'b0, BD, 48'sd0, 32'sd512, 1'b0};
      v[3]  = '{1'b0, BD, 48'sd0, 32'sd256, 1'b0};
      v[4]  = '{1'b0, BD, 48'sd0, 32'sd128, 1'b0};
      v[5]  = '{1'b0, BD, 48'sd0, 32'sd64, 1'b0};
      v[6]  = '{1'b1, BZ, -48'sd1, -32'sd1, 1'b0};
      v[7]  = '{1'b0, BZ, -48'sd2048, -32'sd1, 1'b0};
      v[8]  = '{1'b0, BZ, -48'sd2049, -32'sd2, 1'b0};
      v[9]  = '{1'b0, BZ, 48'sh7fff_ffff_ffff, 32'sh7fff_ffff, 1'b1};
      v[10] = '{1'b0, BZ, 48'sh8000_0000_0000, 32'sh8000_0000, 1'b1};
      for (int i = 0; i < 7; i++)
         v[11+i] = '{(i == 0), BZ, 48'(2048 * (i + 1)), 32'(i + 1), 1'b0};
      // History 7,6,..,1 weighted by 256,512,..,16384 gives -63232 -> floor -31; then -85760 -> -42.
      v[18] = '{1'b0, BM, 48'sd0, -32'sd31, 1'b0};
      v[19] = '{1'b0, BM, 48'sd0, -32'sd42, 1'b0};

      rst = 1'b1;
      clr = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.Xin       = '0;
      for (int i = 0; i < 7; i++) bq[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_yout", bus.Yout, 0);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_ovf", bus.ovf, 0);
      chk("reset_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         if (v[i].do_clr) do_clear();
         xfer($sformatf("row%0d", i), v[i].bs, v[i].xin, v[i].y, v[i].ovf);
      end

      bus.out_ready = 1'b0;
      accept("bp", BZ, 48'sd10240);
      wait_valid(lat);
      chk("bp_latency", lat, 8);
      chk("bp_yout", bus.Yout, 5);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.in_valid = c[0];
         bus.Xin      = 48'sd999999;
         @(posedge clk);
         #1 if (bus.Yout !== 32'sd5 || !bus.out_valid || bus.ovf || bus.in_ready) bad++;
      end
      chk("bp_hold", bad, 0);
      @(negedge clk);
      for (int i = 0; i < 7; i++) bq[i] = '0;
      bus.Xin       = 48'sd18432;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
      @(posedge clk);
      #1 chk("bp_next_accept", bus.in_ready, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      chk("bp_next_latency", lat, 8);
      chk("bp_next_yout", bus.Yout, 9);
      @(posedge clk);

      do_clear();
      xfer("abort_a", BD, 48'sd2097152, 32'sd1024, 1'b0);
      accept("abort_b", BD, 48'sd0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      chk("abort_idle", {bus.out_valid, bus.in_ready}, 2'b01);
      bad = 0;
      repeat (12) begin
         @(posedge clk);
         #1 if (bus.out_valid) bad++;
      end
      chk("abort_silent", bad, 0);
      xfer("abort_r0", BD, 48'sd2097152, 32'sd1024, 1'b0);
      xfer("abort_r1", BD, 48'sd0, 32'sd512, 1'b0);
      xfer("abort_r2", BD, 48'sd0, 32'sd256, 1'b0);

      bus.out_ready = 1'b0;
      accept("arst", BZ, 48'sd6144);
      wait_valid(lat);
      chk("arst_yout_before", bus.Yout, 3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_yout", bus.Yout, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      xfer("arst_after", BD, 48'sd2097152, 32'sd1024, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/iir_dir_pole.md
# iir_dir_pole

Recursive (pole) half of the direct-form IIR filter, placed directly after the symmetric zero section. It takes the 48-bit zero-section sum, subtracts the weighted sum of its own seven previous outputs, scales and saturates the result, and returns a 32-bit sample. One shared 16x32 multiplier is time-multiplexed through a small FSM. Valid/ready handshakes on both sides let it sit between the zero section and the downstream sample sink.

## Interface
- FRAC, 11: fractional bits of B1..B7 and of the zero-section gain (2^FRAC = 1.0).
- clk  in  1  sample clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of history and FSM; ignored while rst is high.
- B1..B7  in  16 each  signed pole coefficients a1..a7, scaled by 2^FRAC.
- Xin  in  48  signed zero-section output for the current sample.
- in_valid  in  1  Xin is valid.
- in_ready  out  1  block can accept a sample; equals (state==IDLE).
- Yout  out  32  signed filtered sample.
- out_valid  out  1  Yout is valid.
- out_ready  in  1  sink accepts Yout.
- ovf  out  1  Yout was saturated; valid with out_valid.

## Operation
- Recurrence: y[n] = sat32( (Xin - sum_{k=1..7} Bk*y[n-k]) >>> FRAC ).
- History registers y_hist[1..7] are 32-bit signed.
- Accumulator is 52-bit signed: 48-bit Xin plus 7 products of 48 bits each, with 3 bits of headroom; no wrap is allowed.
- Products are full 48-bit signed (16x32).
- Shift is arithmetic, so it floors toward -inf. There is no rounding.
- Saturation clips to [-2^31, 2^31-1]. When clipping occurs, ovf=1.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch acc<=sext(Xin) and B1..B7 into coefficient registers, set k<=1, go to MAC.
  - MAC: acc <= acc - Bk_latched*y_hist[k], k<=k+1. After k=7, go to DONE.
  - DONE: Yout<=sat(acc>>>FRAC), ovf<=clip flag, y_hist[1]<=new Yout, y_hist[k+1]<=y_hist[k], out_valid<=1, go to HOLD.
  - HOLD: hold Yout, ovf and out_valid. On out_ready: out_valid<=0, go to IDLE.
- Coefficient input changes after the accept edge do not affect the sample in flight.
- In IDLE, in_valid=0 causes no state change. Xin is don't-care when in_valid=0.
- clr:
  - Next edge: FSM to IDLE; y_hist, acc, k, Yout and ovf cleared to 0; out_valid<=0.
  - Any sample in flight is discarded.
  - clr has priority over every other transition, including out_ready in HOLD.
- rst: same clearing as clr, but immediate and asynchronous; coefficient registers are also cleared.

## Timing
- Reset values: Yout=0, out_valid=0, ovf=0, in_ready=1 (state IDLE), y_hist all 0.
- Accept edge is E0 (in_valid & in_ready).
- MAC edges E1..E7, one product each.
- Edge E8 registers Yout and updates history; out_valid is high after E8.
- Latency from accept to out_valid is 8 clocks.
- in_ready is low from after E0 until the edge that consumes Yout.
- With out_ready held high, Yout is consumed at E9 and the next accept can occur at E10. Maximum rate is one sample per 10 clocks.
- out_valid never drops without out_ready, except on clr or rst.
- Yout is stable for the whole time out_valid is high.
- in_valid while in_ready=0 is ignored. The source must hold it, as with any valid/ready handshake.

## Test plan
- Pass-through: B1..B7=0, Xin=2048000, out_ready=1 -> Yout=1000, ovf=0, out_valid high after E8, in_ready high again after E9.
- First-order decay: B1=-1024, others 0; Xin=2097152 then zeros -> Yout sequence 1024, 512, 256, 128, 64.
- Floor and sign: B=0; Xin=-1 -> Yout=-1; Xin=-2048 -> Yout=-1; Xin=-2049 -> Yout=-2.
- Saturation: B=0; Xin=2^47-1 -> Yout=2147483647, ovf=1; Xin=-2^47 -> Yout=-2147483648, ovf=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> Yout, out_valid and ovf stay constant, in_ready=0, toggling in_valid is ignored. Raising out_ready -> out_valid drops and in_ready rises at that edge; next accept one edge later.
- Abort: run the decay case, assert clr during MAC (after E4) -> no out_valid for that sample, in_ready=1 next cycle. Repeating the impulse reproduces 1024, 512, ... exactly. Async rst asserted mid-HOLD -> out_valid=0 and Yout=0 immediately, without waiting for a clock edge.
